// File: rtl/arrow_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : arrow_scheduler
// Description : Per-beat arrow spawn sequencer with lane limit, beat gap,
//               forced spawns after empty runs and a per-song spawn count.
// Revision    : 1.0 - initial release
// ============================================================================
module arrow_scheduler #(
    parameter int TOTAL_SPAWNS = 16,
    parameter int MIN_GAP      = 1,
    parameter int MAX_LANES    = 2,
    parameter int MAX_EMPTY    = 3,
    parameter int CW           = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          start,
    input  logic          stop,
    input  logic          beat_tick,
    input  logic [3:0]    rand_press,
    input  logic          spawn_ready,
    output logic          spawn_valid,
    output logic [3:0]    spawn_lanes,
    output logic [CW-1:0] spawn_count,
    output logic          busy,
    output logic          done
);

    localparam int EW = $clog2(MAX_EMPTY + 1);
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    localparam logic [EW-1:0] c_max_empty = EW'(MAX_EMPTY);
    localparam logic [GW-1:0] c_min_gap   = GW'(MIN_GAP);
    localparam logic [CW-1:0] c_total     = CW'(TOTAL_SPAWNS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_HOLD  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } t_state;

    t_state          r_state;
    logic            r_valid;
    logic [3:0]      r_lanes;
    logic [CW-1:0]   r_count;
    logic            r_busy;
    logic            r_done;
    logic [EW-1:0]   r_empty_cnt;
    logic [1:0]      r_force_ptr;
    logic [GW-1:0]   r_gap_cnt;

    logic [3:0]      w_limited;
    logic [CW-1:0]   w_count_inc;
    logic [EW-1:0]   w_empty_inc;
    logic [GW-1:0]   w_gap_dec;

    // Keep the lowest-index pressed lanes, at most MAX_LANES of them.
    function automatic logic [3:0] limit_lanes(input logic [3:0] press);
        logic [3:0] sel;
        int         n;
        sel = '0;
        n   = 0;
        for (int i = 0; i < 4; i++) begin
            if (press[i] && (n < MAX_LANES)) begin
                sel[i] = 1'b1;
                n++;
            end
        end
        return sel;
    endfunction

    assign w_limited   = limit_lanes(rand_press);
    assign w_count_inc = r_count + CW'(1);
    assign w_empty_inc = r_empty_cnt + EW'(1);
    assign w_gap_dec   = r_gap_cnt - GW'(1);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_lanes     <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_empty_cnt <= '0;
            r_force_ptr <= '0;
            r_gap_cnt   <= '0;
        end else if (stop) begin
            // A handshake completing on the stop edge still counts.
            if (r_state == S_HOLD && spawn_ready)
                r_count <= w_count_inc;
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_lanes <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_ARMED;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_count     <= '0;
                        r_empty_cnt <= '0;
                        r_force_ptr <= '0;
                    end
                end
                S_ARMED: begin
                    if (beat_tick) begin
                        if (|rand_press) begin
                            r_lanes     <= w_limited;
                            r_valid     <= 1'b1;
                            r_empty_cnt <= '0;
                            r_state     <= S_HOLD;
                        end else if (w_empty_inc == c_max_empty) begin
                            r_lanes     <= 4'b0001 << r_force_ptr;
                            r_force_ptr <= r_force_ptr + 2'd1;
                            r_valid     <= 1'b1;
                            r_empty_cnt <= '0;
                            r_state     <= S_HOLD;
                        end else begin
                            r_empty_cnt <= w_empty_inc;
                        end
                    end
                end
                S_HOLD: begin
                    if (spawn_ready) begin
                        r_count <= w_count_inc;
                        r_valid <= 1'b0;
                        r_lanes <= '0;
                        if (w_count_inc == c_total) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (MIN_GAP > 0) begin
                            r_state   <= S_GAP;
                            r_gap_cnt <= c_min_gap;
                        end else begin
                            r_state <= S_ARMED;
                        end
                    end
                end
                S_GAP: begin
                    // The beat that empties the gap is consumed, not sampled.
                    if (beat_tick) begin
                        r_gap_cnt <= w_gap_dec;
                        if (w_gap_dec == '0)
                            r_state <= S_ARMED;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign spawn_valid = r_valid;
    assign spawn_lanes = r_lanes;
    assign spawn_count = r_count;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: doc/arrow_scheduler.md
Name: arrow_scheduler

Overview:
- Sequences arrow spawning for the game: on each beat tick, samples four per-lane random press bits (one random generator per lane), limits and pads the selection, and hands one spawn word per beat to the arrow display shift logic over a valid/ready handshake.
- Enforces a minimum beat gap between spawns, a maximum number of simultaneous lanes, and a bounded run of empty beats.
- Counts spawns per song and signals completion.

Parameters:
- TOTAL_SPAWNS, 16, spawn events per song before done.
- MIN_GAP, 1, beats ignored after each accepted spawn (0 = none).
- MAX_LANES, 2, maximum lanes set in one spawn word (1..4).
- MAX_EMPTY, 3, consecutive empty beats tolerated before a forced spawn (>=1).
- CW, 8, width of spawn counter; must hold TOTAL_SPAWNS.

Ports:
- Clock  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a song from IDLE or DONE.
- stop  in  1  one-cycle pulse; aborts to IDLE from any state.
- beat_tick  in  1  one-cycle pulse per musical beat.
- rand_press  in  4  per-lane random press bits, bit i = lane i.
- spawn_ready  in  1  display logic can accept a spawn word.
- spawn_valid  out  1  spawn word available.
- spawn_lanes  out  4  lanes to spawn; stable while spawn_valid && !spawn_ready.
- spawn_count  out  CW  accepted spawns this song.
- busy  out  1  high in ARMED, HOLD, GAP.
- done  out  1  high in DONE.

Behaviour:
- Reset (Reset low, asynchronous): state IDLE; spawn_valid=0, spawn_lanes=0, spawn_count=0, busy=0, done=0; empty counter=0; force pointer=0. Reset mid-song discards any held word with no transfer.
- IDLE: start -> ARMED, spawn_count cleared, empty counter and force pointer cleared.
- ARMED: on beat_tick, sample rand_press.
  - Nonzero: keep the lowest-index set bits, up to MAX_LANES (e.g. 1111 -> 0011 with MAX_LANES=2). Register into spawn_lanes and go to HOLD; spawn_valid rises the cycle after beat_tick (latency 1). Empty counter cleared.
  - Zero: empty counter increments. If it reaches MAX_EMPTY, spawn the one-hot lane at the force pointer, then increment the force pointer mod 4 and clear the empty counter; go to HOLD. Otherwise stay in ARMED.
- HOLD: spawn_valid=1. A transfer occurs on the edge where spawn_valid && spawn_ready are both high.
  - On transfer: spawn_count increments; spawn_valid and spawn_lanes clear.
  - Next state: DONE if the new count equals TOTAL_SPAWNS; else GAP if MIN_GAP>0; else ARMED.
  - beat_tick in HOLD is ignored (beats are not queued).
- GAP: a gap counter loaded with MIN_GAP decrements on each beat_tick; at 0 -> ARMED. The beat that drives the counter to 0 is not sampled; the next beat is.
- DONE: done=1, busy=0; spawn_count holds its value. start -> ARMED with the count cleared.
- stop in any state -> IDLE next edge, clearing spawn_valid, spawn_lanes and done; spawn_count is held. If stop and start arrive in the same cycle, stop wins. A transfer in the same cycle as stop is still counted.
- start outside IDLE/DONE is ignored.
- spawn_count never wraps: TOTAL_SPAWNS <= 2^CW - 1 is a parameter legality rule.

Test Plan:
- Reset low mid-HOLD with spawn_lanes=0101 -> all outputs 0 immediately, with no clock edge needed; after release, stays IDLE until start.
- start; beat with rand_press=0101, spawn_ready=1 -> spawn_valid=1 and spawn_lanes=0101 one cycle later, spawn_count=1. The next beat is ignored (MIN_GAP=1); the following beat with 1000 produces spawn_lanes=1000.
- rand_press=1111 on a beat (MAX_LANES=2) -> spawn_lanes=0011. rand_press=1010 -> 1010.
- Three beats with rand_press=0000 -> forced spawn_lanes=0001. Three more empty beats (after the gap) -> 0010.
- spawn_ready=0 for 5 cycles with 2 beats during HOLD -> spawn_valid held, lanes stable, count unchanged. When spawn_ready=1, a single transfer occurs and count increments by 1.
- 16 accepted spawns -> done=1, busy=0, spawn_count=16. stop during the 8th HOLD -> IDLE, spawn_valid=0, spawn_count=7. Simultaneous start and stop -> IDLE.
